wb_data_arbiter: RTL and testbench
==================================

WB_DATA_ARBITER -- requirements
Module: wb_data_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10, giving the byte-address width of the shared memory data port.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 16, giving the number of owner cycles without an ack before forced release.
REQ-003 The module SHALL have parameter MAX_OUTSTANDING, default 3, giving the number of accepted-but-unacked requests allowed (range 1..3).
REQ-004 i_clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous and active-low.
REQ-006 i_mN_cyc, i_mN_stb, i_mN_we  in  1 each  Wishbone cycle, strobe and write-enable from master N (N = 0: CPU data port, N = 1: loader/DMA).
REQ-007 i_mN_addr  in  ADDR_WIDTH  byte address from master N.
REQ-008 i_mN_data  in  32  write data from master N.
REQ-009 i_mN_sel  in  4  byte lane selects from master N.
REQ-010 o_mN_ack  out  1  ack returned to master N.
REQ-011 o_mN_stall  out  1  stall returned to master N.
REQ-012 o_mN_data  out  32  read data returned to master N.
REQ-013 o_s_cyc, o_s_stb, o_s_we  out  1 each  cycle, strobe and write-enable to the memory data port.
REQ-014 o_s_addr  out  ADDR_WIDTH  address to the memory data port.
REQ-015 o_s_data  out  32  write data to the memory data port.
REQ-016 o_s_sel  out  4  byte lane selects to the memory data port.
REQ-017 i_s_ack, i_s_stall  in  1 each  ack and stall from the memory data port.
REQ-018 i_s_data  in  32  read data from the memory data port.
REQ-019 o_grant  out  2  one-hot current owner; 00 when idle.
REQ-020 o_timeout_err  out  1  one-cycle pulse when an ack timeout forces a release.

Function
REQ-021 The FSM SHALL have three states: IDLE, OWN0 and OWN1; o_grant SHALL equal 00, 01 or 10 respectively.
REQ-022 From IDLE, when exactly one master asserts cyc, the FSM SHALL move to that master's OWN state on the next edge, giving one cycle of arbitration latency.
REQ-023 From IDLE, when both masters assert cyc, the FSM SHALL grant the master that was not the last owner (round-robin).
REQ-024 In OWNn, the owner's stb, we, addr, data and sel SHALL be forwarded combinationally to the slave; o_s_cyc SHALL equal i_mn_cyc.
REQ-025 o_s_stb SHALL equal owner stb AND owner cyc AND NOT outstanding-full.
REQ-026 Owner stall SHALL equal i_s_stall OR outstanding-full.
REQ-027 i_s_ack and i_s_data SHALL be routed to the owner only.
REQ-028 The non-owner SHALL see stall=1 and ack=0; o_mN_data SHALL carry i_s_data to both masters.
REQ-029 The outstanding counter SHALL increment on o_s_stb AND NOT i_s_stall, and decrement on i_s_ack; on both in the same cycle it SHALL remain unchanged.
REQ-030 An ack received while the counter is 0 SHALL be dropped, and the counter SHALL NOT underflow.
REQ-031 Release: when the owner deasserts cyc, the FSM SHALL go to the other master's OWN state if that master's cyc is high, else to IDLE.
REQ-032 On release the outstanding counter SHALL clear; acks arriving after release SHALL NOT reach either master.
REQ-033 The timeout counter SHALL count owner cycles with outstanding > 0 and no ack, and SHALL reset on any ack or state change.
REQ-034 When the timeout counter reaches TIMEOUT_CYCLES, the arbiter SHALL pulse o_timeout_err, go to IDLE and clear both counters.
REQ-035 After a timeout, the timed-out master SHALL NOT be re-granted while it keeps cyc asserted; it becomes eligible again once it drops cyc.
REQ-036 The last-owner register SHALL update on every grant.

Reset
REQ-037 While i_rst_n=0 at a clock edge, the FSM SHALL enter IDLE, both counters SHALL clear, and the last owner SHALL be set to m1 so that m0 wins the first tie.
REQ-038 All outputs SHALL be 0 in reset except the non-owner stall outputs (o_m0_stall, o_m1_stall), which SHALL be 1.
REQ-039 Reset mid-transfer SHALL abort ownership with no ack delivered in the following cycle.

Structure
REQ-040 The state encoding, the owner-index constants and the default TIMEOUT_CYCLES value SHALL reside in a shared package wb_arb_pkg.
REQ-041 The block SHALL be a single module, with no sub-module required.

Verification
REQ-042 The bench SHALL cover: reset release, then m0 alone reads 0x10 -> grant 01 the cycle after cyc; ack and data reach m0 only; m1 stall stays 1.
REQ-043 The bench SHALL cover: m0 and m1 raise cyc together from reset -> m0 granted first; after m0 drops cyc, m1 is granted on the next edge with no IDLE cycle.
REQ-044 The bench SHALL cover: m0 issues 4 back-to-back strobes with MAX_OUTSTANDING=3 and the slave withholding acks -> the 4th strobe is stalled until the first ack.
REQ-045 The bench SHALL cover: a write from m1 to 0x20 with sel=0011 -> the slave sees we=1, addr=0x20, sel=0011 unchanged.
REQ-046 The bench SHALL cover: the slave never acks -> o_timeout_err pulses after exactly 16 cycles, grant goes to 00, and the held m0 is not re-granted until it drops cyc.
REQ-047 The bench SHALL cover: i_rst_n=0 during an outstanding m1 read -> grant 00 and no ack to m1 on the next cycle.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone data-port arbiter:
// FSM state encoding, owner indices and the default ack-timeout length.
package wb_arb_pkg;

    // Encoded so the owning states read directly as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    function automatic arb_state_e ownState(input logic ownerIdx);
        return ownerIdx ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone memory data port between
// the CPU data master (m0) and the loader/DMA master (m1), with ack timeout.
module wb_data_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_OUTSTANDING = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_m0_cyc,
    input  logic                  i_m0_stb,
    input  logic                  i_m0_we,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [31:0]           i_m0_data,
    input  logic [3:0]            i_m0_sel,
    output logic                  o_m0_ack,
    output logic                  o_m0_stall,
    output logic [31:0]           o_m0_data,

    input  logic                  i_m1_cyc,
    input  logic                  i_m1_stb,
    input  logic                  i_m1_we,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [31:0]           i_m1_data,
    input  logic [3:0]            i_m1_sel,
    output logic                  o_m1_ack,
    output logic                  o_m1_stall,
    output logic [31:0]           o_m1_data,

    output logic                  o_s_cyc,
    output logic                  o_s_stb,
    output logic                  o_s_we,
    output logic [ADDR_WIDTH-1:0] o_s_addr,
    output logic [31:0]           o_s_data,
    output logic [3:0]            o_s_sel,
    input  logic                  i_s_ack,
    input  logic                  i_s_stall,
    input  logic [31:0]           i_s_data,

    output logic [1:0]            o_grant,
    output logic                  o_timeout_err
);

    localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [1:0]      MAX_OUT   = 2'(MAX_OUTSTANDING);

    arb_state_e        state_q, state_d;
    logic              lastOwner_q, lastOwner_d;
    logic [1:0]        outstanding_q, outstanding_d;
    logic [TMO_W-1:0]  timeoutCnt_q, timeoutCnt_d;
    logic [1:0]        blocked_q, blocked_d;
    logic              timeoutErr_q, timeoutErr_d;

    logic [1:0]            mCyc, mStb, mWe;
    logic [ADDR_WIDTH-1:0] mAddr [2];
    logic [31:0]           mWdata [2];
    logic [3:0]            mSel [2];

    logic       owning;
    logic       ownerIdx;
    logic       full;
    logic       sStb;
    logic       accept;
    logic       ackValid;
    logic [1:0] req;
    logic [TMO_W-1:0] timeoutInc;

    assign mCyc      = {i_m1_cyc, i_m0_cyc};
    assign mStb      = {i_m1_stb, i_m0_stb};
    assign mWe       = {i_m1_we,  i_m0_we};
    assign mAddr[0]  = i_m0_addr;
    assign mAddr[1]  = i_m1_addr;
    assign mWdata[0] = i_m0_data;
    assign mWdata[1] = i_m1_data;
    assign mSel[0]   = i_m0_sel;
    assign mSel[1]   = i_m1_sel;

    // Outputs treat an asserted reset as IDLE even before the reset edge lands.
    assign owning     = i_rst_n && (state_q != ST_IDLE);
    assign ownerIdx   = (state_q == ST_OWN1);
    assign full       = (outstanding_q == MAX_OUT);
    assign sStb       = owning && mStb[ownerIdx] && mCyc[ownerIdx] && !full;
    assign accept     = sStb && !i_s_stall;
    assign ackValid   = owning && i_s_ack && (outstanding_q != 2'd0);
    assign req        = mCyc & ~blocked_q;
    assign timeoutInc = timeoutCnt_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            lastOwner_q   <= OWNER_M1;
            outstanding_q <= 2'd0;
            timeoutCnt_q  <= '0;
            blocked_q     <= 2'b00;
            timeoutErr_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lastOwner_q   <= lastOwner_d;
            outstanding_q <= outstanding_d;
            timeoutCnt_q  <= timeoutCnt_d;
            blocked_q     <= blocked_d;
            timeoutErr_q  <= timeoutErr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lastOwner_d   = lastOwner_q;
        outstanding_d = outstanding_q;
        timeoutCnt_d  = timeoutCnt_q;
        timeoutErr_d  = 1'b0;
        // A timed-out master stays locked out until it lets go of cyc.
        blocked_d     = blocked_q & mCyc;

        unique case (state_q)
            ST_IDLE: begin
                outstanding_d = 2'd0;
                timeoutCnt_d  = '0;
                if (req == 2'b11) begin
                    state_d     = ownState(~lastOwner_q);
                    lastOwner_d = ~lastOwner_q;
                end else if (req[0]) begin
                    state_d     = ST_OWN0;
                    lastOwner_d = OWNER_M0;
                end else if (req[1]) begin
                    state_d     = ST_OWN1;
                    lastOwner_d = OWNER_M1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                if (!mCyc[ownerIdx]) begin
                    outstanding_d = 2'd0;
                    timeoutCnt_d  = '0;
                    if (req[~ownerIdx]) begin
                        state_d     = ownState(~ownerIdx);
                        lastOwner_d = ~ownerIdx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (accept && !ackValid) begin
                        outstanding_d = outstanding_q + 2'd1;
                    end else if (!accept && ackValid) begin
                        outstanding_d = outstanding_q - 2'd1;
                    end

                    if (i_s_ack) begin
                        timeoutCnt_d = '0;
                    end else if (outstanding_q != 2'd0) begin
                        timeoutCnt_d = timeoutInc;
                    end

                    if (!i_s_ack && (outstanding_q != 2'd0) && (timeoutInc == TMO_LIMIT)) begin
                        state_d             = ST_IDLE;
                        outstanding_d       = 2'd0;
                        timeoutCnt_d        = '0;
                        timeoutErr_d        = 1'b1;
                        blocked_d[ownerIdx] = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_s_cyc    = 1'b0;
        o_s_stb    = 1'b0;
        o_s_we     = 1'b0;
        o_s_addr   = '0;
        o_s_data   = '0;
        o_s_sel    = 4'b0000;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;

        if (owning) begin
            o_s_cyc  = mCyc[ownerIdx];
            o_s_stb  = sStb;
            o_s_we   = mWe[ownerIdx];
            o_s_addr = mAddr[ownerIdx];
            o_s_data = mWdata[ownerIdx];
            o_s_sel  = mSel[ownerIdx];
            if (ownerIdx) begin
                o_m1_ack   = ackValid;
                o_m1_stall = i_s_stall || full;
            end else begin
                o_m0_ack   = ackValid;
                o_m0_stall = i_s_stall || full;
            end
        end
    end

    assign o_grant       = owning ? state_q : 2'b00;
    assign o_m0_data     = i_rst_n ? i_s_data : 32'd0;
    assign o_m1_data     = i_rst_n ? i_s_data : 32'd0;
    assign o_timeout_err = i_rst_n && timeoutErr_q;

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Self-checking bench for wb_data_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_wb_data_arbiter;

    localparam int AW   = 10;
    localparam int TO   = 16;
    localparam int MAXO = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstN;
    logic          mCyc [2];
    logic          mStb [2];
    logic          mWe [2];
    logic [AW-1:0] mAddr [2];
    logic [31:0]   mData [2];
    logic [3:0]    mSel [2];
    logic          sAck, sStall;
    logic [31:0]   sData;

    logic          m0Ack, m1Ack, m0Stall, m1Stall;
    logic [31:0]   m0Rd, m1Rd;
    logic          sCyc, sStb, sWe;
    logic [AW-1:0] sAddr;
    logic [31:0]   sWdata;
    logic [3:0]    sSel;
    logic [1:0]    grant;
    logic          tmoErr;

    int checks = 0;
    int failures = 0;

    // Behavioural model: owner 0/1, or 2 for nobody.
    int mdlOwner = 2;
    int mdlLast = 1;
    int mdlCnt = 0;
    int mdlTmo = 0;
    int mdlErr = 0;
    int mdlBlocked [2] = '{0, 0};

    wb_data_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .MAX_OUTSTANDING(MAXO)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_m0_cyc(mCyc[0]), .i_m0_stb(mStb[0]), .i_m0_we(mWe[0]),
        .i_m0_addr(mAddr[0]), .i_m0_data(mData[0]), .i_m0_sel(mSel[0]),
        .o_m0_ack(m0Ack), .o_m0_stall(m0Stall), .o_m0_data(m0Rd),
        .i_m1_cyc(mCyc[1]), .i_m1_stb(mStb[1]), .i_m1_we(mWe[1]),
        .i_m1_addr(mAddr[1]), .i_m1_data(mData[1]), .i_m1_sel(mSel[1]),
        .o_m1_ack(m1Ack), .o_m1_stall(m1Stall), .o_m1_data(m1Rd),
        .o_s_cyc(sCyc), .o_s_stb(sStb), .o_s_we(sWe), .o_s_addr(sAddr),
        .o_s_data(sWdata), .o_s_sel(sSel),
        .i_s_ack(sAck), .i_s_stall(sStall), .i_s_data(sData),
        .o_grant(grant), .o_timeout_err(tmoErr)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n, input logic cyc, input logic stb, input logic we,
                                 input logic [AW-1:0] addr, input logic [31:0] data,
                                 input logic [3:0] sel);
        mCyc[n] = cyc; mStb[n] = stb; mWe[n] = we;
        mAddr[n] = addr; mData[n] = data; mSel[n] = sel;
    endtask

    // Expected outputs follow from who owns the port and how many requests are pending.
    task automatic modelCompare();
        int own;
        bit full;
        logic eCyc, eStb, eWe;
        logic [AW-1:0] eAddr;
        logic [31:0] eWd;
        logic [3:0] eSel;
        logic [1:0] eGrant;
        logic eAck [2];
        logic eStall [2];
        int req [2];
        int nxt, nCnt, nTmo, acc;

        own  = rstN ? mdlOwner : 2;
        full = (mdlCnt == MAXO);
        eCyc = 0; eStb = 0; eWe = 0; eAddr = '0; eWd = '0; eSel = '0;
        if (own < 2) begin
            eCyc  = mCyc[own];
            eStb  = mStb[own] && mCyc[own] && !full;
            eWe   = mWe[own];
            eAddr = mAddr[own];
            eWd   = mData[own];
            eSel  = mSel[own];
        end
        for (int n = 0; n < 2; n++) begin
            eAck[n]   = (own == n) && sAck && (mdlCnt > 0);
            eStall[n] = (own == n) ? (sStall || full) : 1'b1;
        end
        eGrant = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;

        checkOutput("mdl_grant", grant, eGrant);
        checkOutput("mdl_s_cyc", sCyc, eCyc);
        checkOutput("mdl_s_stb", sStb, eStb);
        checkOutput("mdl_s_we", sWe, eWe);
        checkOutput("mdl_s_addr", sAddr, eAddr);
        checkOutput("mdl_s_data", sWdata, eWd);
        checkOutput("mdl_s_sel", sSel, eSel);
        checkOutput("mdl_m0_ack", m0Ack, eAck[0]);
        checkOutput("mdl_m1_ack", m1Ack, eAck[1]);
        checkOutput("mdl_m0_stall", m0Stall, eStall[0]);
        checkOutput("mdl_m1_stall", m1Stall, eStall[1]);
        checkOutput("mdl_m0_data", m0Rd, rstN ? sData : 32'd0);
        checkOutput("mdl_m1_data", m1Rd, rstN ? sData : 32'd0);
        checkOutput("mdl_timeout_err", tmoErr, (rstN && mdlErr != 0) ? 1 : 0);

        if (!rstN) begin
            mdlOwner = 2; mdlLast = 1; mdlCnt = 0; mdlTmo = 0; mdlErr = 0;
            mdlBlocked[0] = 0; mdlBlocked[1] = 0;
            return;
        end

        mdlErr = 0;
        for (int n = 0; n < 2; n++) req[n] = (mCyc[n] && mdlBlocked[n] == 0) ? 1 : 0;
        for (int n = 0; n < 2; n++) if (!mCyc[n]) mdlBlocked[n] = 0;
        nxt = mdlOwner;

        if (mdlOwner == 2) begin
            if (req[0] == 1 && req[1] == 1) nxt = 1 - mdlLast;
            else if (req[0] == 1) nxt = 0;
            else if (req[1] == 1) nxt = 1;
            mdlCnt = 0; mdlTmo = 0;
        end else if (!mCyc[mdlOwner]) begin
            nxt = (req[1 - mdlOwner] == 1) ? 1 - mdlOwner : 2;
            mdlCnt = 0; mdlTmo = 0;
        end else begin
            acc  = (eStb && !sStall) ? 1 : 0;
            nCnt = mdlCnt + acc - (eAck[mdlOwner] ? 1 : 0);
            nTmo = sAck ? 0 : ((mdlCnt > 0) ? mdlTmo + 1 : mdlTmo);
            if (nTmo == TO) begin
                mdlBlocked[mdlOwner] = 1;
                nxt = 2; nCnt = 0; nTmo = 0; mdlErr = 1;
            end
            mdlCnt = nCnt; mdlTmo = nTmo;
        end

        if (nxt != mdlOwner && nxt < 2) mdlLast = nxt;
        mdlOwner = nxt;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        modelCompare();
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            sampleCycle();
            nextEdge();
        end
    endtask

    initial begin
        int ackPct, stallPct, togglePct;

        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        sAck = 1'b0; sStall = 1'b0; sData = 32'h5555AAAA;

        sampleCycle();
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_m0_stall", m0Stall, 1);
        checkOutput("rst_m1_stall", m1Stall, 1);
        checkOutput("rst_s_cyc", sCyc, 0);
        checkOutput("rst_m0_data", m0Rd, 0);
        nextEdge();
        runCycles(1);

        // m0 alone reads 0x10
        rstN = 1'b1; sData = 32'd0;
        applyStimulus(0, 1, 1, 0, 10'h10, 32'd0, 4'hF);
        sampleCycle();
        checkOutput("arb_latency_grant", grant, 2'b00);
        nextEdge();
        sampleCycle();
        checkOutput("m0_grant", grant, 2'b01);
        checkOutput("m0_s_addr", sAddr, 10'h10);
        checkOutput("m0_s_stb", sStb, 1);
        checkOutput("m1_stall_nonowner", m1Stall, 1);
        nextEdge();
        mStb[0] = 1'b0; sAck = 1'b1; sData = 32'hCAFEF00D;
        sampleCycle();
        checkOutput("m0_ack", m0Ack, 1);
        checkOutput("m1_ack_nonowner", m1Ack, 0);
        checkOutput("m0_rdata", m0Rd, 32'hCAFEF00D);
        checkOutput("m1_stall_during_ack", m1Stall, 1);
        nextEdge();
        sAck = 1'b0; mCyc[0] = 1'b0;
        sampleCycle();
        checkOutput("release_grant_held", grant, 2'b01);
        nextEdge();
        sampleCycle();
        checkOutput("release_idle", grant, 2'b00);
        nextEdge();

        // simultaneous request straight out of reset
        rstN = 1'b0;
        runCycles(1);
        rstN = 1'b1;
        mCyc[0] = 1'b1; mCyc[1] = 1'b1;
        sampleCycle();
        nextEdge();
        sampleCycle();
        checkOutput("tie_m0_first", grant, 2'b01);
        nextEdge();
        mCyc[0] = 1'b0;
        sampleCycle();
        nextEdge();
        sampleCycle();
        checkOutput("handover_m1", grant, 2'b10);
        nextEdge();
        mCyc[1] = 1'b0;
        runCycles(2);

        // four back-to-back strobes against a slave withholding acks
        applyStimulus(0, 1, 1, 0, 10'h40, 32'd0, 4'hF);
        sampleCycle();
        nextEdge();
        for (int i = 0; i < 3; i++) begin
            sampleCycle();
            checkOutput("b2b_stb", sStb, 1);
            nextEdge();
            mAddr[0] = mAddr[0] + 10'd4;
        end
        sampleCycle();
        checkOutput("full_stall", m0Stall, 1);
        checkOutput("full_no_stb", sStb, 0);
        nextEdge();
        sampleCycle();
        checkOutput("full_stall_held", m0Stall, 1);
        nextEdge();
        sAck = 1'b1;
        sampleCycle();
        checkOutput("full_stall_ack_cycle", m0Stall, 1);
        checkOutput("first_ack", m0Ack, 1);
        nextEdge();
        sAck = 1'b0;
        sampleCycle();
        checkOutput("fourth_stb_issued", sStb, 1);
        checkOutput("fourth_not_stalled", m0Stall, 0);
        nextEdge();
        mStb[0] = 1'b0; sAck = 1'b1;
        runCycles(3);
        sAck = 1'b0; mCyc[0] = 1'b0;
        runCycles(2);

        // m1 write passes through untouched
        applyStimulus(1, 1, 1, 1, 10'h20, 32'h12345678, 4'b0011);
        sampleCycle();
        nextEdge();
        sampleCycle();
        checkOutput("wr_grant", grant, 2'b10);
        checkOutput("wr_we", sWe, 1);
        checkOutput("wr_addr", sAddr, 10'h20);
        checkOutput("wr_sel", sSel, 4'b0011);
        checkOutput("wr_data", sWdata, 32'h12345678);
        nextEdge();
        mStb[1] = 1'b0; sAck = 1'b1;
        sampleCycle();
        checkOutput("wr_ack_m1", m1Ack, 1);
        checkOutput("wr_no_ack_m0", m0Ack, 0);
        nextEdge();
        sAck = 1'b0; mCyc[1] = 1'b0;
        runCycles(2);

        // slave never acks: forced release after the timeout
        applyStimulus(0, 1, 1, 0, 10'h80, 32'd0, 4'hF);
        sampleCycle();
        nextEdge();
        sampleCycle();
        checkOutput("tmo_grant", grant, 2'b01);
        nextEdge();
        mStb[0] = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            sampleCycle();
            if (k == TO) begin
                checkOutput("tmo_err_not_early", tmoErr, 0);
                checkOutput("tmo_grant_before", grant, 2'b01);
            end
            nextEdge();
        end
        sampleCycle();
        checkOutput("tmo_err_pulse", tmoErr, 1);
        checkOutput("tmo_grant_idle", grant, 2'b00);
        nextEdge();
        sampleCycle();
        checkOutput("tmo_err_one_cycle", tmoErr, 0);
        nextEdge();
        runCycles(3);
        sampleCycle();
        checkOutput("held_m0_blocked", grant, 2'b00);
        nextEdge();
        mCyc[0] = 1'b0;
        runCycles(1);
        mCyc[0] = 1'b1;
        sampleCycle();
        nextEdge();
        sampleCycle();
        checkOutput("m0_regranted", grant, 2'b01);
        nextEdge();
        mCyc[0] = 1'b0;
        runCycles(2);

        // reset during an outstanding m1 read
        applyStimulus(1, 1, 1, 0, 10'h30, 32'd0, 4'hF);
        sampleCycle();
        nextEdge();
        sampleCycle();
        nextEdge();
        mStb[1] = 1'b0; rstN = 1'b0; sAck = 1'b1; sData = 32'h0BADBEEF;
        sampleCycle();
        checkOutput("rst_mid_grant", grant, 2'b00);
        checkOutput("rst_mid_no_ack", m1Ack, 0);
        nextEdge();
        rstN = 1'b1;
        sampleCycle();
        checkOutput("post_rst_grant", grant, 2'b00);
        checkOutput("post_rst_no_ack", m1Ack, 0);
        nextEdge();
        sAck = 1'b0;
        sampleCycle();
        checkOutput("post_rst_regrant", grant, 2'b10);
        nextEdge();
        mCyc[1] = 1'b0;
        runCycles(2);

        // randomized traffic, model-checked every cycle
        ackPct = 35; stallPct = 25; togglePct = 8;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: ackPct = 0;
                    1: ackPct = 4;
                    default: ackPct = 40;
                endcase
                togglePct = ($urandom_range(0, 1) == 0) ? 2 : 10;
                stallPct  = $urandom_range(0, 40);
            end
            rstN = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 99) < togglePct) mCyc[n] = ~mCyc[n];
                mStb[n]  = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
                mWe[n]   = $urandom_range(0, 1) == 1;
                mAddr[n] = AW'($urandom);
                mData[n] = $urandom;
                mSel[n]  = 4'($urandom);
            end
            sAck   = ($urandom_range(0, 99) < ackPct) ? 1'b1 : 1'b0;
            sStall = ($urandom_range(0, 99) < stallPct) ? 1'b1 : 1'b0;
            sData  = $urandom;
            sampleCycle();
            nextEdge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
